// File: rtl/id_pkg.sv
// Shared encodings for the MIPS32 ID stage: opcodes, functs, ALU op/select codes
// and the ID/EX control bubble.
package id_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;

    typedef enum logic [7:0] {
        ALUOP_NOP = 8'h00,
        ALUOP_AND = 8'h24,
        ALUOP_OR  = 8'h25,
        ALUOP_XOR = 8'h26,
        ALUOP_NOR = 8'h27,
        ALUOP_SLL = 8'h7C,
        ALUOP_SRL = 8'h02,
        ALUOP_SRA = 8'h03
    } aluop_e;

    typedef enum logic [2:0] {
        ALUSEL_NOP   = 3'd0,
        ALUSEL_LOGIC = 3'd1,
        ALUSEL_SHIFT = 3'd2
    } alusel_e;

    typedef struct packed {
        logic    valid;
        aluop_e  aluop;
        alusel_e alusel;
        logic    wreg;
        logic    invalid;
    } idex_ctrl_t;

    localparam idex_ctrl_t IDEX_BUBBLE = '{
        valid:   1'b0,
        aluop:   ALUOP_NOP,
        alusel:  ALUSEL_NOP,
        wreg:    1'b0,
        invalid: 1'b0
    };

endpackage

// File: rtl/id_opnd_sel.sv
// One source operand: immediate / zero / EX / MEM / regfile priority mux and its hazard hit.
// ID_FORWARD_EN selects forwarding muxes; otherwise any EX/MEM hit is reported as a hazard.
module id_opnd_sel
    import id_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              read_en,
    input  logic [REG_AW-1:0] addr,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              ex_wreg,
    input  logic [REG_AW-1:0] ex_wd,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              ex_is_load,
    input  logic              mem_wreg,
    input  logic [REG_AW-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] opnd,
    output logic              hazard_hit
);

    logic ex_hit;
    logic mem_hit;

    // $0 never matches a producer: it is hardwired zero.
    assign ex_hit  = read_en && (addr != '0) && ex_wreg  && (ex_wd  == addr);
    assign mem_hit = read_en && (addr != '0) && mem_wreg && (mem_wd == addr);

`ifdef ID_FORWARD_EN
    always_comb begin
        opnd = rf_data;
        if (!read_en)
            opnd = imm;
        else if (addr == '0)
            opnd = '0;
        else if (ex_hit)
            opnd = ex_wdata;
        else if (mem_hit)
            opnd = mem_wdata;
    end

    // A load's data is not ready in EX, so only that case must interlock.
    assign hazard_hit = ex_hit && ex_is_load;
`else
    logic unused_fwd;

    always_comb begin
        opnd = rf_data;
        if (!read_en)
            opnd = imm;
        else if (addr == '0)
            opnd = '0;
    end

    // Without bypass paths the instruction waits until the producer has written back.
    assign hazard_hit = ex_hit || mem_hit;
    assign unused_fwd = ^{ex_wdata, mem_wdata, ex_is_load};
`endif

endmodule

// File: rtl/id_pipe.sv
// MIPS32 decode stage: logic/LUI/shift decode, operand select, load-use interlock, ID/EX register.
// Optional macro ID_FORWARD_EN enables EX/MEM forwarding.
module id_pipe
    import id_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3
) (
    input  logic                clk,
    input  logic                Rst_n,
    input  logic [31:0]         pc_i,
    input  logic [31:0]         inst_i,
    input  logic                inst_valid_i,
    input  logic                stall_i,
    input  logic                flush_i,
    output logic                reg1_read_o,
    output logic                reg2_read_o,
    output logic [REG_AW-1:0]   reg1_addr_o,
    output logic [REG_AW-1:0]   reg2_addr_o,
    input  logic [DATA_W-1:0]   reg1_data_i,
    input  logic [DATA_W-1:0]   reg2_data_i,
    input  logic                ex_wreg_i,
    input  logic [REG_AW-1:0]   ex_wd_i,
    input  logic [DATA_W-1:0]   ex_wdata_i,
    input  logic                ex_is_load_i,
    input  logic                mem_wreg_i,
    input  logic [REG_AW-1:0]   mem_wd_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,
    output logic                stall_req_o,
    output logic                ex_valid_o,
    output logic [31:0]         ex_pc_o,
    output logic [ALUOP_W-1:0]  ex_aluop_o,
    output logic [ALUSEL_W-1:0] ex_alusel_o,
    output logic [DATA_W-1:0]   ex_reg1_o,
    output logic [DATA_W-1:0]   ex_reg2_o,
    output logic [REG_AW-1:0]   ex_wd_o,
    output logic                ex_wreg_o,
    output logic                ex_inst_invalid_o
);

    logic [5:0]        op;
    logic [5:0]        funct;
    logic [4:0]        shamt;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;

    idex_ctrl_t        ctrl_d;
    idex_ctrl_t        ctrl_q;
    logic              dec_read1;
    logic              dec_read2;
    logic [REG_AW-1:0] dec_wd;
    logic [DATA_W-1:0] dec_imm;
    logic [DATA_W-1:0] opnd1;
    logic [DATA_W-1:0] opnd2;
    logic              hz1;
    logic              hz2;

    logic [31:0]       pc_q;
    logic [DATA_W-1:0] reg1_q;
    logic [DATA_W-1:0] reg2_q;
    logic [REG_AW-1:0] wd_q;

    assign op    = inst_i[31:26];
    assign funct = inst_i[5:0];
    assign shamt = inst_i[10:6];
    assign rs    = REG_AW'(inst_i[25:21]);
    assign rt    = REG_AW'(inst_i[20:16]);
    assign rd    = REG_AW'(inst_i[15:11]);

    // Unrecognised encodings fall through the defaults as reserved instructions.
    always_comb begin
        ctrl_d         = IDEX_BUBBLE;
        ctrl_d.valid   = inst_valid_i;
        ctrl_d.invalid = 1'b1;
        dec_read1      = 1'b0;
        dec_read2      = 1'b0;
        dec_wd         = '0;
        dec_imm        = '0;
        case (op)
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl_d.invalid = 1'b0;
                ctrl_d.wreg    = 1'b1;
                ctrl_d.alusel  = ALUSEL_LOGIC;
                dec_read1      = 1'b1;
                dec_wd         = rt;
                dec_imm        = DATA_W'(inst_i[15:0]);
                case (op)
                    OP_ANDI: ctrl_d.aluop = ALUOP_AND;
                    OP_XORI: ctrl_d.aluop = ALUOP_XOR;
                    default: ctrl_d.aluop = ALUOP_OR;
                endcase
                if (op == OP_LUI)
                    dec_imm = DATA_W'({inst_i[15:0], 16'h0000});
            end
            OP_SPECIAL: begin
                case (funct)
                    FN_AND, FN_OR, FN_XOR, FN_NOR: begin
                        if (shamt == 5'd0) begin
                            ctrl_d.invalid = 1'b0;
                            ctrl_d.wreg    = 1'b1;
                            ctrl_d.alusel  = ALUSEL_LOGIC;
                            dec_read1      = 1'b1;
                            dec_read2      = 1'b1;
                            dec_wd         = rd;
                            case (funct)
                                FN_AND:  ctrl_d.aluop = ALUOP_AND;
                                FN_OR:   ctrl_d.aluop = ALUOP_OR;
                                FN_XOR:  ctrl_d.aluop = ALUOP_XOR;
                                default: ctrl_d.aluop = ALUOP_NOR;
                            endcase
                        end
                    end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        ctrl_d.invalid = 1'b0;
                        ctrl_d.wreg    = 1'b1;
                        ctrl_d.alusel  = ALUSEL_SHIFT;
                        dec_read2      = 1'b1;
                        dec_wd         = rd;
                        dec_imm        = DATA_W'(shamt);
                        case (funct)
                            FN_SLL:  ctrl_d.aluop = ALUOP_SLL;
                            FN_SRL:  ctrl_d.aluop = ALUOP_SRL;
                            default: ctrl_d.aluop = ALUOP_SRA;
                        endcase
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    id_opnd_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_opnd1 (
        .read_en    (dec_read1),
        .addr       (rs),
        .imm        (dec_imm),
        .rf_data    (reg1_data_i),
        .ex_wreg    (ex_wreg_i),
        .ex_wd      (ex_wd_i),
        .ex_wdata   (ex_wdata_i),
        .ex_is_load (ex_is_load_i),
        .mem_wreg   (mem_wreg_i),
        .mem_wd     (mem_wd_i),
        .mem_wdata  (mem_wdata_i),
        .opnd       (opnd1),
        .hazard_hit (hz1)
    );

    id_opnd_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_opnd2 (
        .read_en    (dec_read2),
        .addr       (rt),
        .imm        (dec_imm),
        .rf_data    (reg2_data_i),
        .ex_wreg    (ex_wreg_i),
        .ex_wd      (ex_wd_i),
        .ex_wdata   (ex_wdata_i),
        .ex_is_load (ex_is_load_i),
        .mem_wreg   (mem_wreg_i),
        .mem_wd     (mem_wd_i),
        .mem_wdata  (mem_wdata_i),
        .opnd       (opnd2),
        .hazard_hit (hz2)
    );

    assign reg1_read_o = Rst_n && dec_read1;
    assign reg2_read_o = Rst_n && dec_read2;
    assign reg1_addr_o = Rst_n ? rs : '0;
    assign reg2_addr_o = Rst_n ? rt : '0;
    assign stall_req_o = Rst_n && inst_valid_i && (hz1 || hz2);

    // Reset, flush and an interlock all load a bubble; a downstream stall holds.
    always_ff @(posedge clk) begin
        if (!Rst_n || flush_i || (!stall_i && stall_req_o)) begin
            ctrl_q <= IDEX_BUBBLE;
            pc_q   <= '0;
            reg1_q <= '0;
            reg2_q <= '0;
            wd_q   <= '0;
        end else if (!stall_i) begin
            ctrl_q <= ctrl_d;
            pc_q   <= pc_i;
            reg1_q <= opnd1;
            reg2_q <= opnd2;
            wd_q   <= dec_wd;
        end
    end

    assign ex_valid_o        = ctrl_q.valid;
    assign ex_pc_o           = pc_q;
    assign ex_aluop_o        = ALUOP_W'(ctrl_q.aluop);
    assign ex_alusel_o       = ALUSEL_W'(ctrl_q.alusel);
    assign ex_reg1_o         = reg1_q;
    assign ex_reg2_o         = reg2_q;
    assign ex_wd_o           = wd_q;
    assign ex_wreg_o         = ctrl_q.wreg;
    assign ex_inst_invalid_o = ctrl_q.invalid;

endmodule

// File: tb/tb_id_pipe.sv
// Self-checking bench for id_pipe: instruction-level reference model compared every
// cycle, plus directed vectors with literal expectations.
module tb_id_pipe;
    import id_pkg::*;

    logic        clk = 1'b0;
    logic        Rst_n;
    logic [31:0] pc_i, inst_i;
    logic        inst_valid_i, stall_i, flush_i;
    logic        reg1_read_o, reg2_read_o;
    logic [4:0]  reg1_addr_o, reg2_addr_o;
    logic [31:0] reg1_data_i, reg2_data_i;
    logic        ex_wreg_i, ex_is_load_i, mem_wreg_i;
    logic [4:0]  ex_wd_i, mem_wd_i;
    logic [31:0] ex_wdata_i, mem_wdata_i;
    logic        stall_req_o, ex_valid_o, ex_wreg_o, ex_inst_invalid_o;
    logic [31:0] ex_pc_o, ex_reg1_o, ex_reg2_o;
    logic [7:0]  ex_aluop_o;
    logic [2:0]  ex_alusel_o;
    logic [4:0]  ex_wd_o;

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    id_pipe dut (
        .clk(clk), .Rst_n(Rst_n), .pc_i(pc_i), .inst_i(inst_i), .inst_valid_i(inst_valid_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
        .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
        .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
        .stall_req_o(stall_req_o), .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o),
        .ex_aluop_o(ex_aluop_o), .ex_alusel_o(ex_alusel_o),
        .ex_reg1_o(ex_reg1_o), .ex_reg2_o(ex_reg2_o), .ex_wd_o(ex_wd_o),
        .ex_wreg_o(ex_wreg_o), .ex_inst_invalid_o(ex_inst_invalid_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Instruction semantics from the decode table.
    typedef struct packed {
        logic        r1, r2, wreg, bad;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [4:0]  wd;
        logic [31:0] imm;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] w);
        dec_t d;
        logic [5:0] op, fn;
        op = w[31:26];
        fn = w[5:0];
        d = '0;
        d.bad = 1'b1;
        if (op == 6'b001101 || op == 6'b001100 || op == 6'b001110 || op == 6'b001111) begin
            d = '{r1: 1'b1, r2: 1'b0, wreg: 1'b1, bad: 1'b0, aluop: ALUOP_OR, alusel: ALUSEL_LOGIC,
                  wd: w[20:16], imm: {16'h0, w[15:0]}};
            if (op == 6'b001100) d.aluop = ALUOP_AND;
            if (op == 6'b001110) d.aluop = ALUOP_XOR;
            if (op == 6'b001111) d.imm = {w[15:0], 16'h0};
        end else if (op == 6'b000000 && w[10:6] == 5'd0 && fn[5:2] == 4'b1001) begin
            d = '{r1: 1'b1, r2: 1'b1, wreg: 1'b1, bad: 1'b0, aluop: 8'h24 + 8'(fn[1:0]),
                  alusel: ALUSEL_LOGIC, wd: w[15:11], imm: 32'h0};
        end else if (op == 6'b000000 && (fn == 6'd0 || fn == 6'd2 || fn == 6'd3)) begin
            d = '{r1: 1'b0, r2: 1'b1, wreg: 1'b1, bad: 1'b0, aluop: ALUOP_SLL, alusel: ALUSEL_SHIFT,
                  wd: w[15:11], imm: {27'h0, w[10:6]}};
            if (fn == 6'd2) d.aluop = ALUOP_SRL;
            if (fn == 6'd3) d.aluop = ALUOP_SRA;
        end
        return d;
    endfunction

    function automatic logic src_hazard(input logic en, input logic [4:0] a);
        logic ex_m, mem_m;
        ex_m  = en && a != 0 && ex_wreg_i && ex_wd_i == a;
        mem_m = en && a != 0 && mem_wreg_i && mem_wd_i == a;
`ifdef ID_FORWARD_EN
        return ex_m && ex_is_load_i;
`else
        return ex_m || mem_m;
`endif
    endfunction

    function automatic logic [31:0] src_val(input logic en, input logic [4:0] a,
                                            input logic [31:0] imm, input logic [31:0] rf);
        if (!en) return imm;
        if (a == 0) return 32'h0;
`ifdef ID_FORWARD_EN
        if (ex_wreg_i && ex_wd_i == a) return ex_wdata_i;
        if (mem_wreg_i && mem_wd_i == a) return mem_wdata_i;
`endif
        return rf;
    endfunction

    function automatic logic exp_stall();
        dec_t d;
        d = decode(inst_i);
        return Rst_n && inst_valid_i &&
               (src_hazard(d.r1, inst_i[25:21]) || src_hazard(d.r2, inst_i[20:16]));
    endfunction

    // Model of the ID/EX contents.
    logic        m_valid = 0, m_wreg = 0, m_bad = 0;
    logic [7:0]  m_aluop = 0;
    logic [2:0]  m_alusel = 0;
    logic [4:0]  m_wd = 0;
    logic [31:0] m_pc = 0, m_r1 = 0, m_r2 = 0;

    always @(posedge clk) begin
        dec_t d;
        d = decode(inst_i);
        if (!Rst_n || flush_i || (!stall_i && exp_stall())) begin
            m_valid <= 0; m_wreg <= 0; m_bad <= 0; m_aluop <= 0; m_alusel <= 0;
            m_wd <= 0; m_pc <= 0; m_r1 <= 0; m_r2 <= 0;
        end else if (!stall_i) begin
            m_valid  <= inst_valid_i;
            m_wreg   <= d.wreg;
            m_bad    <= d.bad;
            m_aluop  <= d.aluop;
            m_alusel <= d.alusel;
            m_wd     <= d.wd;
            m_pc     <= pc_i;
            m_r1     <= src_val(d.r1, inst_i[25:21], d.imm, reg1_data_i);
            m_r2     <= src_val(d.r2, inst_i[20:16], d.imm, reg2_data_i);
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            dec_t d;
            d = decode(inst_i);
            chk("ex_valid", ex_valid_o, m_valid);
            chk("ex_pc", ex_pc_o, m_pc);
            chk("ex_aluop", ex_aluop_o, m_aluop);
            chk("ex_alusel", ex_alusel_o, m_alusel);
            chk("ex_reg1", ex_reg1_o, m_r1);
            chk("ex_reg2", ex_reg2_o, m_r2);
            chk("ex_wd", ex_wd_o, m_wd);
            chk("ex_wreg", ex_wreg_o, m_wreg);
            chk("ex_invalid", ex_inst_invalid_o, m_bad);
            chk("stall_req", stall_req_o, exp_stall());
            chk("reg1_read", reg1_read_o, Rst_n && d.r1);
            chk("reg2_read", reg2_read_o, Rst_n && d.r2);
            chk("reg1_addr", reg1_addr_o, Rst_n ? inst_i[25:21] : 5'd0);
            chk("reg2_addr", reg2_addr_o, Rst_n ? inst_i[20:16] : 5'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_hz();
        ex_wreg_i = 0; ex_wd_i = 0; ex_wdata_i = 0; ex_is_load_i = 0;
        mem_wreg_i = 0; mem_wd_i = 0; mem_wdata_i = 0;
    endtask

    logic [31:0] itab [12] = '{32'h3422_1234, 32'h0022_1825, 32'h0086_2824, 32'h0008_38C0,
                               32'h0002_4942, 32'h0003_57C3, 32'h0027_3027, 32'hFC00_0000,
                               32'h3C05_ABCD, 32'h3083_8000, 32'h38A7_00FF, 32'h0022_1865};

    initial begin
        Rst_n = 0; pc_i = 32'h100; inst_i = 32'h3422_1234; inst_valid_i = 1;
        stall_i = 0; flush_i = 0; reg1_data_i = 32'hF0; reg2_data_i = 0;
        clear_hz();
        #1;
        chk("rst_comb_read1", reg1_read_o, 0);
        chk("rst_comb_addr2", reg2_addr_o, 0);
        tick();
        check_en = 1;
        tick();
        chk("rst_valid", ex_valid_o, 0);
        chk("rst_aluop", ex_aluop_o, 0);
        chk("rst_wreg", ex_wreg_o, 0);

        // ORI $2,$1,0x1234
        Rst_n = 1;
        tick();
        chk("ori_aluop", ex_aluop_o, ALUOP_OR);
        chk("ori_reg1", ex_reg1_o, 32'hF0);
        chk("ori_reg2", ex_reg2_o, 32'h1234);
        chk("ori_wd", ex_wd_o, 2);
        chk("ori_wreg", ex_wreg_o, 1);
        chk("ori_pc", ex_pc_o, 32'h100);

        // OR $3,$1,$2 with $1 produced in both EX and MEM
        inst_i = 32'h0022_1825; pc_i = 32'h104; reg1_data_i = 32'h11; reg2_data_i = 32'h22;
        ex_wreg_i = 1; ex_wd_i = 1; ex_wdata_i = 32'hAAAA_0000;
        mem_wreg_i = 1; mem_wd_i = 1; mem_wdata_i = 32'h5;
        #1;
`ifdef ID_FORWARD_EN
        chk("fwd_stall", stall_req_o, 0);
        tick();
        chk("fwd_ex_wins", ex_reg1_o, 32'hAAAA_0000);
        chk("fwd_reg2", ex_reg2_o, 32'h22);
`else
        chk("nofwd_stall", stall_req_o, 1);
        tick();
        chk("nofwd_bubble", ex_valid_o, 0);
`endif
        ex_wd_i = 0; mem_wreg_i = 0;
        tick();
        chk("wd0_regfile", ex_reg1_o, 32'h11);
        chk("wd0_valid", ex_valid_o, 1);

        // load to $4 in EX, AND $5,$4,$6 in ID
        inst_i = 32'h0086_2824; pc_i = 32'h108; reg1_data_i = 32'h1111; reg2_data_i = 32'h66;
        ex_wreg_i = 1; ex_wd_i = 4; ex_is_load_i = 1; ex_wdata_i = 32'hDEAD;
        #1;
        chk("lu_stall", stall_req_o, 1);
        tick();
        chk("lu_bubble_valid", ex_valid_o, 0);
        chk("lu_bubble_wreg", ex_wreg_o, 0);
        clear_hz();
        mem_wreg_i = 1; mem_wd_i = 4; mem_wdata_i = 32'hBEEF;
        #1;
`ifdef ID_FORWARD_EN
        chk("lu_release", stall_req_o, 0);
        tick();
        chk("lu_mem_fwd", ex_reg1_o, 32'hBEEF);
        chk("lu_issue", ex_valid_o, 1);
`else
        chk("lu_mem_wait", stall_req_o, 1);
        tick();
        chk("lu_mem_bubble", ex_valid_o, 0);
`endif
        mem_wreg_i = 0; reg1_data_i = 32'hBEEF;
        tick();
        chk("and_reg1", ex_reg1_o, 32'hBEEF);
        chk("and_reg2", ex_reg2_o, 32'h66);
        chk("and_aluop", ex_aluop_o, ALUOP_AND);
        chk("and_wd", ex_wd_o, 5);

        // SLL $7,$8,3
        inst_i = 32'h0008_38C0; reg2_data_i = 32'h80;
        #1;
        chk("sll_read1", reg1_read_o, 0);
        chk("sll_addr2", reg2_addr_o, 8);
        tick();
        chk("sll_reg1", ex_reg1_o, 3);
        chk("sll_reg2", ex_reg2_o, 32'h80);
        chk("sll_alusel", ex_alusel_o, ALUSEL_SHIFT);
        chk("sll_aluop", ex_aluop_o, ALUOP_SLL);
        chk("sll_wd", ex_wd_o, 7);

        inst_i = 32'hFC00_0000;
        tick();
        chk("inv_flag", ex_inst_invalid_o, 1);
        chk("inv_wreg", ex_wreg_o, 0);
        chk("inv_valid", ex_valid_o, 1);

        inst_i = 32'h3C05_ABCD;
        tick();
        chk("lui_reg2", ex_reg2_o, 32'hABCD_0000);
        chk("lui_reg1", ex_reg1_o, 0);
        chk("lui_wd", ex_wd_o, 5);

        inst_i = 32'h0;
        tick();
        chk("nop_aluop", ex_aluop_o, ALUOP_SLL);
        chk("nop_invalid", ex_inst_invalid_o, 0);
        chk("nop_wd", ex_wd_o, 0);

        // XORI $7,$5,0xFF then hold under downstream stall
        inst_i = 32'h38A7_00FF; reg1_data_i = 32'h0F0F; pc_i = 32'h200;
        tick();
        chk("xori_reg1", ex_reg1_o, 32'h0F0F);
        stall_i = 1; inst_i = 32'h3422_1234; pc_i = 32'h204;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold_reg2", ex_reg2_o, 32'hFF);
            chk("stall_hold_aluop", ex_aluop_o, ALUOP_XOR);
            chk("stall_hold_pc", ex_pc_o, 32'h200);
        end
        flush_i = 1;
        tick();
        chk("flush_over_stall", ex_valid_o, 0);
        chk("flush_aluop", ex_aluop_o, 0);
        flush_i = 0; stall_i = 0;
        tick();
        chk("reload_valid", ex_valid_o, 1);
        stall_i = 1; Rst_n = 0;
        tick();
        chk("rst_in_stall_valid", ex_valid_o, 0);
        chk("rst_in_stall_reg1", ex_reg1_o, 0);
        chk("rst_in_stall_pc", ex_pc_o, 0);
        Rst_n = 1; stall_i = 0;

        // mixed traffic, checked by the model only
        for (int i = 0; i < 40; i++) begin
            inst_i       = itab[$urandom_range(0, 11)];
            inst_valid_i = ($urandom_range(0, 5) != 0);
            pc_i         = 32'h300 + 32'(i * 4);
            reg1_data_i  = $urandom;
            reg2_data_i  = $urandom;
            ex_wreg_i    = $urandom_range(0, 1);
            ex_wd_i      = 5'($urandom_range(0, 8));
            ex_wdata_i   = $urandom;
            ex_is_load_i = $urandom_range(0, 1);
            mem_wreg_i   = $urandom_range(0, 1);
            mem_wd_i     = 5'($urandom_range(0, 8));
            mem_wdata_i  = $urandom;
            stall_i      = ($urandom_range(0, 6) == 0);
            flush_i      = ($urandom_range(0, 9) == 0);
            tick();
        end
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
